// File: rtl/plab4_net_router_output_ctrl_arbiter_tp.sv
// Output-port arbiter with a time-division domain schedule (D0/D1) and per-domain round-robin.
// Optional guard cycle at the end of each slot: define PLAB4_NET_OUTPUT_CTRL_GUARD_EN.
module plab4_net_router_output_ctrl_arbiter_tp #(
    parameter  int p_slot_cycles = 8,
    parameter  int p_num_reqs    = 3,
    localparam int c_slot_nbits  = $clog2(p_slot_cycles)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [p_num_reqs-1:0] reqs_d0,
    input  logic [p_num_reqs-1:0] reqs_d1,
    output logic [p_num_reqs-1:0] grants_d0,
    output logic [p_num_reqs-1:0] grants_d1,
    output logic                  out_val_d0,
    output logic                  out_val_d1,
    input  logic                  out_rdy_d0,
    input  logic                  out_rdy_d1,
    output logic [1:0]            sel,
    output logic                  domain
);

    localparam logic [c_slot_nbits-1:0] c_slot_last = c_slot_nbits'(p_slot_cycles - 1);

    logic [c_slot_nbits-1:0]   slot_cnt_q, slot_cnt_d;
    logic                      domain_q, domain_d;
    logic [p_num_reqs-1:0]     prio_d0_q, prio_d0_d;
    logic [p_num_reqs-1:0]     prio_d1_q, prio_d1_d;
    logic [1:0]                sel_q, sel_d;

    logic                      slot_last;
    logic                      guard;
    logic [p_num_reqs-1:0]     act_reqs;
    logic [p_num_reqs-1:0]     act_prio;
    logic                      act_rdy;
    logic                      grant_en;
    logic [2*p_num_reqs-1:0]   reqs_dbl;
    logic [2*p_num_reqs-1:0]   prio_dbl;
    logic [2*p_num_reqs-1:0]   grant_dbl;
    logic [p_num_reqs-1:0]     act_grant;
    logic [p_num_reqs-1:0]     grant_rot;
    logic [1:0]                sel_enc;

    // The schedule depends only on time, never on traffic.
    assign slot_last  = (slot_cnt_q == c_slot_last);
    assign slot_cnt_d = slot_last ? '0 : slot_cnt_q + c_slot_nbits'(1);
    assign domain_d   = domain_q ^ slot_last;

`ifdef PLAB4_NET_OUTPUT_CTRL_GUARD_EN
    assign guard = slot_last;
`else
    assign guard = 1'b0;
`endif

    assign act_reqs = domain_q ? reqs_d1    : reqs_d0;
    assign act_rdy  = domain_q ? out_rdy_d1 : out_rdy_d0;
    assign act_prio = domain_q ? prio_d1_q  : prio_d0_q;
    // Reset is folded in so grants drop the instant reset asserts.
    assign grant_en = reset && act_rdy && (|act_reqs) && !guard;

    // Doubled-vector trick: first set request at or after the one-hot pointer, with wrap.
    assign reqs_dbl  = {act_reqs, act_reqs};
    assign prio_dbl  = {{p_num_reqs{1'b0}}, act_prio};
    assign grant_dbl = reqs_dbl & ~(reqs_dbl - prio_dbl);
    assign act_grant = grant_en ? (grant_dbl[2*p_num_reqs-1:p_num_reqs] | grant_dbl[p_num_reqs-1:0])
                                : '0;
    assign grant_rot = {act_grant[p_num_reqs-2:0], act_grant[p_num_reqs-1]};

    assign grants_d0  = domain_q ? '0 : act_grant;
    assign grants_d1  = domain_q ? act_grant : '0;
    assign out_val_d0 = |grants_d0;
    assign out_val_d1 = |grants_d1;

    always_comb begin
        sel_enc = 2'd0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (act_grant[i]) sel_enc = 2'(i);
        end
    end

    // sel keeps its last value between grants so it never reveals the schedule.
    assign sel    = grant_en ? sel_enc : sel_q;
    assign sel_d  = sel;
    assign domain = domain_q;

    assign prio_d0_d = (grant_en && !domain_q) ? grant_rot : prio_d0_q;
    assign prio_d1_d = (grant_en &&  domain_q) ? grant_rot : prio_d1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt_q <= '0;
            domain_q   <= 1'b0;
            prio_d0_q  <= p_num_reqs'(1);
            prio_d1_q  <= p_num_reqs'(1);
            sel_q      <= 2'd0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            domain_q   <= domain_d;
            prio_d0_q  <= prio_d0_d;
            prio_d1_q  <= prio_d1_d;
            sel_q      <= sel_d;
        end
    end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl_arbiter_tp.sv
// Directed bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_plab4_net_router_output_ctrl_arbiter_tp;

    logic       clk;
    logic       reset;
    logic [2:0] reqs_d0, reqs_d1;
    logic [2:0] grants_d0, grants_d1;
    logic       out_val_d0, out_val_d1;
    logic       out_rdy_d0, out_rdy_d1;
    logic [1:0] sel;
    logic       domain;

    typedef struct packed {
        logic       dom;
        logic [2:0] g0;
        logic [2:0] g1;
        logic [1:0] sel;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    plab4_net_router_output_ctrl_arbiter_tp dut (
        .clk        (clk),
        .reset      (reset),
        .reqs_d0    (reqs_d0),
        .reqs_d1    (reqs_d1),
        .grants_d0  (grants_d0),
        .grants_d1  (grants_d1),
        .out_val_d0 (out_val_d0),
        .out_val_d1 (out_val_d1),
        .out_rdy_d0 (out_rdy_d0),
        .out_rdy_d1 (out_rdy_d1),
        .sel        (sel),
        .domain     (domain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, req);
        end
    endtask

    // Monitor: one line per transaction, compares every field it owns.
    initial begin
        int   idx;
        exp_t e;
        idx = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("domain",     idx, {2'b0, domain},     {2'b0, e.dom});
                chk("grants_d0",  idx, grants_d0,          e.g0);
                chk("grants_d1",  idx, grants_d1,          e.g1);
                chk("out_val_d0", idx, {2'b0, out_val_d0}, {2'b0, |e.g0});
                chk("out_val_d1", idx, {2'b0, out_val_d1}, {2'b0, |e.g1});
                chk("sel",        idx, {1'b0, sel},        {1'b0, e.sel});
                $display("step %0d: rst=%b dom=%b g0=%b g1=%b sel=%0d", idx, reset, domain,
                         grants_d0, grants_d1, sel);
                idx++;
            end
        end
    end

    task automatic step(input logic rst, input logic [2:0] r0, input logic [2:0] r1,
                        input logic rdy0, input logic rdy1,
                        input logic edom, input logic [2:0] eg0, input logic [2:0] eg1,
                        input logic [1:0] esel);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = rst;
        reqs_d0    = r0;
        reqs_d1    = r1;
        out_rdy_d0 = rdy0;
        out_rdy_d1 = rdy1;
        e.dom = edom;
        e.g0  = eg0;
        e.g1  = eg1;
        e.sel = esel;
        exp_q.push_back(e);
        step_no++;
    endtask

    initial begin
        reset      = 1'b0;
        reqs_d0    = 3'b000;
        reqs_d1    = 3'b000;
        out_rdy_d0 = 1'b0;
        out_rdy_d1 = 1'b0;

        // Reset held, then idle schedule: D0 for cycles 0-7, D1 for 8-15.
        step(0, 3'b000, 3'b000, 1, 1, 0, 3'b000, 3'b000, 0);
        step(0, 3'b111, 3'b111, 1, 1, 0, 3'b000, 3'b000, 0);
        for (int c = 0; c < 16; c++)
            step(1, 3'b000, 3'b000, 1, 1, (c >= 8), 3'b000, 3'b000, 0);

        // Cycles 16-23, D0 slot: D0 rotates, D1 requests ignored.
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b001, 3'b000, 0);
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b010, 3'b000, 1);
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b100, 3'b000, 2);
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b001, 3'b000, 0);
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b010, 3'b000, 1);
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b100, 3'b000, 2);
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b001, 3'b000, 0);
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b010, 3'b000, 1);

        // Cycles 24-31, D1 slot: fresh D1 pointer, then rdy toggling with req 100.
        step(1, 3'b111, 3'b111, 1, 1, 1, 3'b000, 3'b001, 0);
        step(1, 3'b111, 3'b111, 1, 1, 1, 3'b000, 3'b010, 1);
        step(1, 3'b111, 3'b100, 1, 0, 1, 3'b000, 3'b000, 1);
        step(1, 3'b111, 3'b100, 1, 1, 1, 3'b000, 3'b100, 2);
        step(1, 3'b111, 3'b100, 1, 0, 1, 3'b000, 3'b000, 2);
        step(1, 3'b111, 3'b100, 1, 1, 1, 3'b000, 3'b100, 2);
        step(1, 3'b111, 3'b001, 1, 1, 1, 3'b000, 3'b001, 0);
        step(1, 3'b111, 3'b000, 1, 1, 1, 3'b000, 3'b000, 0);

        // Cycles 32-36, D0 resumes from its saved pointer (100).
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b100, 3'b000, 2);
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b001, 3'b000, 0);
        step(1, 3'b111, 3'b111, 0, 1, 0, 3'b000, 3'b000, 0);
        step(1, 3'b010, 3'b111, 1, 1, 0, 3'b010, 3'b000, 1);
        step(1, 3'b111, 3'b111, 0, 1, 0, 3'b000, 3'b000, 1);

        // Cycle 37 (slot_cnt 5): asynchronous reset with requests pending.
        step(0, 3'b111, 3'b111, 1, 1, 0, 3'b000, 3'b000, 0);

        // After release: counter, domain and both pointers restart from reset values.
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b001, 3'b000, 0);
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b010, 3'b000, 1);
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b100, 3'b000, 2);
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b001, 3'b000, 0);
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b010, 3'b000, 1);
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b100, 3'b000, 2);
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b001, 3'b000, 0);
        step(1, 3'b111, 3'b111, 1, 1, 0, 3'b010, 3'b000, 1);
        step(1, 3'b111, 3'b111, 1, 1, 1, 3'b000, 3'b001, 0);
        step(1, 3'b111, 3'b111, 1, 1, 1, 3'b000, 3'b010, 1);
        step(1, 3'b000, 3'b000, 1, 1, 1, 3'b000, 3'b000, 1);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/plab4_net_router_output_ctrl_arbiter_tp.md
Name: plab4_net_router_output_ctrl_arbiter_tp

Overview:
- Output-port control for one router output terminal, with timing-channel protection between two security domains (D0, D1).
- Takes per-domain request vectors from the three router input controllers and runs a per-domain round-robin arbitration. Returns one-hot grants, the crossbar select and the output valid.
- Owns the time-division domain schedule: a slot counter alternates the active domain every p_slot_cycles cycles, independent of traffic. The inactive domain's requests never affect grants, pointer state or timing.

Parameters:
- p_slot_cycles, 8, cycles per domain time slot; legal range ≥ 2.
- p_num_reqs, 3, number of requesting input terminals; fixed at 3 and not meant to be overridden.
- c_slot_nbits, $clog2(p_slot_cycles), slot counter width; derived, not set from outside.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- reqs_d0  input  3  D0 requests from input terminals 0..2
- reqs_d1  input  3  D1 requests from input terminals 0..2
- grants_d0  output  3  one-hot D0 grant to input terminals
- grants_d1  output  3  one-hot D1 grant to input terminals
- out_val_d0  output  1  D0 message valid on this output
- out_val_d1  output  1  D1 message valid on this output
- out_rdy_d0  input  1  downstream ready for D0
- out_rdy_d1  input  1  downstream ready for D1
- sel  output  2  crossbar select: index of the granted input (0..2)
- domain  output  1  active domain; public (L) schedule state

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-slot or mid-grant):
  - slot_cnt=0, domain=0.
  - prio_d0=prio_d1=3'b001 (input 0 highest priority).
  - grants_d0=grants_d1=0, out_val_*=0, sel=0 while reset is asserted and in the first cycle after release if there are no requests.
- Slot counter:
  - Increments every cycle.
  - At slot_cnt==p_slot_cycles-1 it wraps to 0 and domain toggles on the same edge.
  - The counter is never influenced by reqs, rdy or grants.
- Arbitration is combinational and applies to the active domain only (domain==0 → D0, 1 → D1). Same-cycle latency from req to grant.
  - A grant is issued only if the active domain's out_rdy=1 and its reqs≠0.
  - The winner is the first requester at or after the priority pointer, scanning 0→1→2 with wrap.
- Inactive domain: grants=0 and out_val=0. Its reqs are ignored; its pointer is held.
- out_val_dX = |grants_dX.
- sel = index of the set grant bit. sel holds its registered last value when no grant is issued, so sel is glitch-free and carries no domain-dependent timing.
- Pointer update at posedge clk, only when the active domain issued a grant: prio_dX = grant rotated left by 1 (2→0 wraps).
- Boundary cases:
  - Slot boundary: a grant issued in the last slot cycle completes on that edge. The next cycle arbitrates the other domain with its own saved pointer.
  - All three requesting continuously: grants rotate 0,1,2,0…
  - out_rdy low: no grant and no pointer move.
  - Requests from the inactive domain asserted during its off-slot do not change any output.

Optional Feature:
- Macro: PLAB4_NET_OUTPUT_CTRL_GUARD_EN
- Defined: the last cycle of every slot (slot_cnt==p_slot_cycles-1) is a guard cycle. Grants are forced to 0 for both domains and pointers are held, so no transfer straddles a domain switch. Effective slot bandwidth is p_slot_cycles-1.
- Undefined: every cycle of the slot is grantable.

Test Plan:
- Reset release, no requests: domain=0 for cycles 0-7, 1 for cycles 8-15, 0 at cycle 16; all grants 0 throughout.
- D0 slot, reqs_d0=3'b111, out_rdy_d0=1 → grants_d0 = 001, 010, 100, 001 on successive cycles; sel = 0, 1, 2, 0.
- D0 slot, reqs_d1=3'b111, out_rdy_d1=1 → grants_d1=0 and out_val_d1=0. At the switch to D1, the first grants_d1=001 (pointer unchanged by the off-slot requests).
- D1 slot, reqs_d1=3'b100, out_rdy_d1 toggling 0/1 → grant 100 only in rdy=1 cycles; prio_d1 becomes 001 after the first grant.
- Assert reset low mid-slot at slot_cnt=5 with a grant active → grants 0 immediately (asynchronous); after release, slot_cnt=0, domain=0, pointers at 001.
- With the macro defined, continuous reqs_d0=3'b001 → grant absent at slot_cnt=7, no D1 grant at cycle 8 unless requested; 7 grants per 8-cycle D0 slot.
